// File: rtl/conv_window_generator.sv
// Raster-order KxK sliding-window generator feeding the convolution stage.
// Registered output on the edge that accepts the completing pixel; no backpressure, idle cycles simply stall.
module conv_window_generator #(
    parameter int KERNEL_SIZE  = 5,
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [DATA_WIDTH-1:0]                      pixel_in,
    input  logic                                       pixel_valid,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_out,
    output logic                                       window_valid,
    output logic                                       frame_done
);

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST     = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(KERNEL_SIZE - 2);

    typedef enum logic {S_FILL, S_STREAM} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_emit;
    logic            w_frame_end;

    logic [DATA_WIDTH-1:0] r_lb [KERNEL_SIZE-1][IMAGE_WIDTH];
    // Only columns 1..K-1 are kept: the oldest column is shifted out on the next pixel.
    logic [DATA_WIDTH-1:0] r_win [KERNEL_SIZE][KERNEL_SIZE-1];
    logic [DATA_WIDTH-1:0] w_col_new [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] w_win [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] w_pack;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (pixel_valid && w_col_last) begin
            case (r_state)
                S_FILL:   if (r_row == ROW_FILL_LAST) w_state_nxt = S_STREAM;
                S_STREAM: if (w_row_last)             w_state_nxt = S_FILL;
                default:  w_state_nxt = S_FILL;
            endcase
        end
    end

    always_comb begin
        w_emit      = pixel_valid && (r_state == S_STREAM) && (r_col >= COL_FIRST);
        w_frame_end = w_emit && w_col_last && w_row_last;
    end

    // Top window row comes from the deepest line buffer, bottom row from the live pixel.
    always_comb begin
        w_col_new[KERNEL_SIZE-1] = pixel_in;
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            w_col_new[r] = r_lb[KERNEL_SIZE-2-r][IMAGE_WIDTH-1];
        end
    end

    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                w_win[r][c] = r_win[r][c];
            end
            w_win[r][KERNEL_SIZE-1] = w_col_new[r];
        end
    end

    always_comb begin
        w_pack = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                w_pack[DATA_WIDTH*(r*KERNEL_SIZE+c) +: DATA_WIDTH] = w_win[r][c];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (pixel_valid) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_win[r][c] <= w_win[r][c+1];
                end
            end
            for (int n = 0; n < KERNEL_SIZE - 1; n++) begin
                r_lb[n][0] <= (n == 0) ? pixel_in : r_lb[(n == 0) ? 0 : n-1][IMAGE_WIDTH-1];
                for (int i = 1; i < IMAGE_WIDTH; i++) begin
                    r_lb[n][i] <= r_lb[n][i-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_col        <= '0;
            r_row        <= '0;
            window_out   <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= w_emit;
            frame_done   <= w_frame_end;
            if (w_emit) begin
                window_out <= w_pack;
            end
            if (pixel_valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule
